// File: rtl/zion_clr_en_dff_pipe.sv
// zion_clr_en_dff_pipe
//   Elastic register pipe of DEPTH stages with valid/ready handshake on both
//   sides, a global enable that freezes the pipe, a synchronous flush, and a
//   registered occupancy count. Empty stages collapse, so a beat advances
//   whenever the stage ahead of it is empty or is itself advancing.
//
// Ports
//   clk   : clock, all state changes on the rising edge
//   rst   : asynchronous reset, active low
//   iEn   : global enable; low freezes every stage and blocks both handshakes
//   iClr  : synchronous flush; empties the pipe and reloads INI_DATA
//   iVld  : upstream beat valid
//   iDat  : upstream beat data
//   oRdy  : upstream may transfer this cycle (combinational from iRdy)
//   oVld  : downstream beat valid
//   oDat  : downstream beat data (last stage)
//   iRdy  : downstream accepts this cycle
//   oCnt  : number of occupied stages, registered
module zion_clr_en_dff_pipe #(
    parameter int unsigned      WIDTH    = 8,
    parameter int unsigned      DEPTH    = 2,
    parameter logic [WIDTH-1:0] INI_DATA = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       iEn,
    input  logic                       iClr,
    input  logic                       iVld,
    input  logic [WIDTH-1:0]           iDat,
    output logic                       oRdy,
    output logic                       oVld,
    output logic [WIDTH-1:0]           oDat,
    input  logic                       iRdy,
    output logic [$clog2(DEPTH+1)-1:0] oCnt
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    if (WIDTH < 1 || DEPTH < 1 || $bits(INI_DATA) > WIDTH) begin : gParamCheck
        $error("zion_clr_en_dff_pipe: illegal parameters WIDTH=%0d DEPTH=%0d", WIDTH, DEPTH);
`ifdef CHECK_ERR_EXIT
        $fatal(1, "zion_clr_en_dff_pipe: parameter check failed");
`endif
    end

    logic                 act;
    logic                 room;
    logic                 inXfer;
    logic                 outXfer;
    logic [DEPTH-1:0]     v;
    logic [DEPTH-1:0]     mv;
    logic [DEPTH-1:0]     srcV;
    logic [WIDTH-1:0]     d    [DEPTH];
    logic [WIDTH-1:0]     srcD [DEPTH];
    logic [CW-1:0]        cnt;

    // rst is folded in so that oRdy reads low while reset is asserted.
    assign act = iEn & ~iClr & rst;

    // mv[k] = act & (!v[k] | mv[k+1]) unrolled from the output end: a stage
    // may advance if any stage at or ahead of it is empty, or the sink is
    // ready. The running 'room' term avoids a self-referencing vector.
    always_comb begin
        room = iRdy;
        mv   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            room              = room | ~v[DEPTH-1-i];
            mv[DEPTH-1-i]     = act & room;
        end
    end

    // Source of each stage: upstream port for stage 0, previous stage otherwise.
    always_comb begin
        srcV[0] = iVld;
        srcD[0] = iDat;
        for (int unsigned k = 1; k < DEPTH; k++) begin
            srcV[k] = v[k-1];
            srcD[k] = d[k-1];
        end
    end

    assign oRdy    = mv[0];
    assign oVld    = v[DEPTH-1] & act;
    assign oDat    = d[DEPTH-1];
    assign oCnt    = cnt;
    assign inXfer  = iVld & oRdy;
    assign outXfer = oVld & iRdy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v   <= '0;
            cnt <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                d[k] <= INI_DATA;
            end
        end else if (iClr) begin
            v   <= '0;
            cnt <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                d[k] <= INI_DATA;
            end
        end else if (iEn) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                if (mv[k]) begin
                    v[k] <= srcV[k];
                    // Data of an empty source is not copied; the stage keeps its word.
                    if (srcV[k]) begin
                        d[k] <= srcD[k];
                    end
                end
            end
            case ({inXfer, outXfer})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_zion_clr_en_dff_pipe.sv
module tb_zion_clr_en_dff_pipe;

    localparam int unsigned W   = 8;
    localparam int unsigned D   = 3;
    localparam logic [7:0]  INI = 8'h5A;

    logic       clk = 1'b0;
    logic       rst;
    logic       iEn, iClr, iVld, iRdy;
    logic [7:0] iDat;
    logic       oRdy, oVld;
    logic [7:0] oDat;
    logic [1:0] oCnt;

    always #5 clk = ~clk;

    zion_clr_en_dff_pipe #(
        .WIDTH    (W),
        .DEPTH    (D),
        .INI_DATA (INI)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .iEn  (iEn),
        .iClr (iClr),
        .iVld (iVld),
        .iDat (iDat),
        .oRdy (oRdy),
        .oVld (oVld),
        .oDat (oDat),
        .iRdy (iRdy),
        .oCnt (oCnt)
    );

    int nChecks = 0;
    int nPass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       en, clr, vld;
        logic [7:0] dat;
        logic       rdy;
        logic       eVld;
        logic [7:0] eDat;
        logic       eRdy;
        logic [1:0] eCnt;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic en, input logic clr, input logic vld,
                                input logic [7:0] dat, input logic rdy,
                                input logic eVld, input logic [7:0] eDat,
                                input logic eRdy, input logic [1:0] eCnt);
        vec_t x;
        x.en = en; x.clr = clr; x.vld = vld; x.dat = dat; x.rdy = rdy;
        x.eVld = eVld; x.eDat = eDat; x.eRdy = eRdy; x.eCnt = eCnt;
        tbl.push_back(x);
    endfunction

    // ---------------- reference model ----------------
    // Beats held as an ordered queue (oldest first) with the stage each one
    // occupies; a beat moves if the slot ahead is free or its occupant moves.
    logic [7:0] mq[$];
    int         mp[$];
    logic [7:0] lastOut;

    function automatic void mdlReset();
        mq.delete();
        mp.delete();
        lastOut = INI;
    endfunction

    function automatic void mdlMoves(input logic rdy, output bit mvs[$]);
        mvs.delete();
        for (int i = 0; i < mq.size(); i++) begin
            if (i == 0) mvs.push_back(mp[0] < D - 1 || rdy);
            else        mvs.push_back(mp[i-1] > mp[i] + 1 || mvs[i-1]);
        end
    endfunction

    function automatic void mdlEval(input logic en, input logic clr, input logic rdy,
                                    output logic eVld, output logic [7:0] eDat,
                                    output logic eRdy, output int eCnt);
        bit mvs[$];
        bit act;
        bit atOut;
        int n;
        act   = en && !clr;
        n     = mq.size();
        atOut = n > 0 && mp[0] == D - 1;
        mdlMoves(rdy, mvs);
        eVld  = act && atOut;
        eDat  = atOut ? mq[0] : lastOut;
        eRdy  = act && (n == 0 || mp[n-1] > 0 || mvs[n-1]);
        eCnt  = n;
    endfunction

    function automatic void mdlAdvance(input logic en, input logic clr, input logic vld,
                                       input logic [7:0] dat, input logic rdy);
        bit mvs[$];
        bit acc;
        bit pop;
        int n;
        if (clr) begin
            mdlReset();
            return;
        end
        if (!en) return;
        n   = mq.size();
        mdlMoves(rdy, mvs);
        acc = (n == 0) || mp[n-1] > 0 || mvs[n-1];
        pop = n > 0 && mp[0] == D - 1 && mvs[0];
        for (int i = 0; i < n; i++) begin
            if (mvs[i]) begin
                mp[i] = mp[i] + 1;
                if (mp[i] == D - 1) lastOut = mq[i];
            end
        end
        if (pop) begin
            void'(mq.pop_front());
            void'(mp.pop_front());
        end
        if (acc && vld) begin
            mq.push_back(dat);
            mp.push_back(0);
        end
    endfunction

    task automatic drive(input logic en, input logic clr, input logic vld,
                         input logic [7:0] dat, input logic rdy);
        iEn = en; iClr = clr; iVld = vld; iDat = dat; iRdy = rdy;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic       eVld, eRdy;
        logic [7:0] eDat;
        int         eCnt;
        int         lat;

        // ---- reset state (inputs active, reset must dominate) ----
        rst = 1'b0;
        drive(1, 0, 1, 8'hFF, 1);
        #12;
        chk("reset oVld", 32'(oVld), 32'(0));
        chk("reset oRdy", 32'(oRdy), 32'(0));
        chk("reset oDat", 32'(oDat), 32'(INI));
        chk("reset oCnt", 32'(oCnt), 32'(0));
        #4;               // t=16, just after the edge at 15
        rst = 1'b1;

        // fill: 11,22,33 then drain
        add(1,0,1,8'h11,1, 0,8'h5A,1,0);
        add(1,0,1,8'h22,1, 0,8'h5A,1,1);
        add(1,0,1,8'h33,1, 0,8'h5A,1,2);
        add(1,0,0,8'h00,1, 1,8'h11,1,3);
        add(1,0,0,8'h00,1, 1,8'h22,1,2);
        add(1,0,0,8'h00,1, 1,8'h33,1,1);
        add(1,0,0,8'h00,1, 0,8'h33,1,0);
        // backpressure
        add(1,0,1,8'h11,0, 0,8'h33,1,0);
        add(1,0,1,8'h22,0, 0,8'h33,1,1);
        add(1,0,1,8'h33,0, 0,8'h33,1,2);
        add(1,0,1,8'h44,0, 1,8'h11,0,3);
        add(1,0,1,8'h44,1, 1,8'h11,1,3);
        add(1,0,0,8'h00,1, 1,8'h22,1,3);
        add(1,0,0,8'h00,1, 1,8'h33,1,2);
        add(1,0,0,8'h00,1, 1,8'h44,1,1);
        // bubble collapse
        add(1,0,1,8'hA0,0, 0,8'h44,1,0);
        add(1,0,0,8'h00,0, 0,8'h44,1,1);
        add(1,0,1,8'hA1,0, 0,8'h44,1,1);
        add(1,0,0,8'h00,0, 1,8'hA0,1,2);
        add(1,0,0,8'h00,0, 1,8'hA0,1,2);
        add(1,0,0,8'h00,1, 1,8'hA0,1,2);
        add(1,0,0,8'h00,1, 1,8'hA1,1,1);
        // clear with a full pipe and a beat presented
        add(1,0,1,8'hC1,0, 0,8'hA1,1,0);
        add(1,0,1,8'hC2,0, 0,8'hA1,1,1);
        add(1,0,1,8'hC3,0, 0,8'hA1,1,2);
        add(1,1,1,8'hEE,1, 0,8'hC1,0,3);
        add(1,0,0,8'h00,1, 0,8'h5A,1,0);
        add(1,0,0,8'h00,1, 0,8'h5A,1,0);
        add(1,0,0,8'h00,1, 0,8'h5A,1,0);
        // enable freeze
        add(1,0,1,8'hE1,0, 0,8'h5A,1,0);
        add(1,0,1,8'hE2,0, 0,8'h5A,1,1);
        add(1,0,1,8'hE3,0, 0,8'h5A,1,2);
        add(0,0,1,8'hE4,1, 0,8'hE1,0,3);
        add(0,0,1,8'hE4,1, 0,8'hE1,0,3);
        add(1,0,0,8'h00,1, 1,8'hE1,1,3);
        add(1,0,0,8'h00,1, 1,8'hE2,1,2);
        add(1,0,0,8'h00,1, 1,8'hE3,1,1);
        add(1,0,0,8'h00,1, 0,8'hE3,1,0);

        foreach (tbl[i]) begin
            drive(tbl[i].en, tbl[i].clr, tbl[i].vld, tbl[i].dat, tbl[i].rdy);
            #4;
            chk($sformatf("vec%0d oVld", i), 32'(oVld), 32'(tbl[i].eVld));
            chk($sformatf("vec%0d oDat", i), 32'(oDat), 32'(tbl[i].eDat));
            chk($sformatf("vec%0d oRdy", i), 32'(oRdy), 32'(tbl[i].eRdy));
            chk($sformatf("vec%0d oCnt", i), 32'(oCnt), 32'(tbl[i].eCnt));
            @(posedge clk); #1;
        end

        // ---- asynchronous reset with two beats in flight ----
        drive(1, 0, 1, 8'h71, 0);
        @(posedge clk); #1;
        drive(1, 0, 1, 8'h72, 0);
        @(posedge clk); #1;
        chk("inflight oCnt", 32'(oCnt), 32'(2));
        #2;
        rst = 1'b0;
        #1;               // between edges: no clock has occurred
        chk("async oVld", 32'(oVld), 32'(0));
        chk("async oCnt", 32'(oCnt), 32'(0));
        chk("async oDat", 32'(oDat), 32'(INI));
        chk("async oRdy", 32'(oRdy), 32'(0));
        @(posedge clk); #1;
        chk("held oCnt", 32'(oCnt), 32'(0));
        rst = 1'b1;
        drive(1, 0, 1, 8'h77, 1);
        #4;
        chk("post-reset oRdy", 32'(oRdy), 32'(1));
        @(posedge clk); #1;
        lat = -1;
        for (int c = 1; c <= 8; c++) begin
            drive(1, 0, 0, 8'h00, 1);
            #4;
            if (oVld === 1'b1) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
        end
        chk("latency", 32'(lat), 32'(D));
        chk("latency oDat", 32'(oDat), 32'(8'h77));

        // ---- randomized traffic against the model ----
        rst = 1'b0;
        #1;
        mdlReset();
        @(posedge clk); #1;
        rst = 1'b1;
        for (int c = 0; c < 600; c++) begin
            logic       en, clr, vld, rdy;
            logic [7:0] dat;
            en  = ($urandom_range(0, 9) != 0);
            clr = ($urandom_range(0, 29) == 0);
            vld = ($urandom_range(0, 9) < 7);
            rdy = ($urandom_range(0, 9) < 6);
            dat = 8'($urandom);
            drive(en, clr, vld, dat, rdy);
            #4;
            mdlEval(en, clr, rdy, eVld, eDat, eRdy, eCnt);
            chk($sformatf("rnd%0d oVld", c), 32'(oVld), 32'(eVld));
            chk($sformatf("rnd%0d oDat", c), 32'(oDat), 32'(eDat));
            chk($sformatf("rnd%0d oRdy", c), 32'(oRdy), 32'(eRdy));
            chk($sformatf("rnd%0d oCnt", c), 32'(oCnt), 32'(eCnt));
            mdlAdvance(en, clr, vld, dat, rdy);
            @(posedge clk); #1;
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
